// File: rtl/ft245_device_emulator.sv
// FTDI-side model of the FT245 asynchronous FIFO interface: RX FIFO fed by a host port and
// drained over RD#, TX FIFO filled over WR# and drained by a host port.
module ft245_device_emulator #(
  parameter int unsigned RX_DEPTH      = 16,
  parameter int unsigned TX_DEPTH      = 16,
  parameter int unsigned RXF_PRECHARGE = 2,
  parameter int unsigned TXE_PRECHARGE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       rxf_245,
  input  logic       rx_245,
  output logic       txe_245,
  input  logic       wr_245,
  input  logic [7:0] host_tx_data,
  input  logic       host_tx_valid,
  output logic       host_tx_ready,
  output logic [7:0] host_rx_data,
  output logic       host_rx_valid,
  input  logic       host_rx_ready,
  output logic       err_rd,
  output logic       err_wr,
  output logic       err_bus
);

  localparam int unsigned RxAw = $clog2(RX_DEPTH);
  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxCw = RxAw + 1;
  localparam int unsigned TxCw = TxAw + 1;
  localparam int unsigned RpW  = $clog2(RXF_PRECHARGE + 1);
  localparam int unsigned WpW  = $clog2(TXE_PRECHARGE + 1);

  localparam logic [RxCw-1:0] RxFull = RxCw'(RX_DEPTH);
  localparam logic [TxCw-1:0] TxFull = TxCw'(TX_DEPTH);

  typedef enum logic [1:0] {RIdle, RActive, RPrecharge} rd_state_e;
  typedef enum logic [1:0] {WIdle, WActive, WPrecharge} wr_state_e;

  // Strobe edge detection
  logic r_rd_q, r_wr_q;
  logic w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;

  // RX FIFO (host -> FPGA)
  logic [7:0]      r_rx_mem [RX_DEPTH];
  logic [RxAw-1:0] r_rx_wr_ptr, r_rx_rd_ptr;
  logic [RxCw-1:0] r_rx_count, w_rx_count_d;
  logic            w_rx_push, w_rx_pop;

  // TX FIFO (FPGA -> host)
  logic [7:0]      r_tx_mem [TX_DEPTH];
  logic [TxAw-1:0] r_tx_wr_ptr, r_tx_rd_ptr;
  logic [TxCw-1:0] r_tx_count, w_tx_count_d;
  logic            w_tx_push, w_tx_pop;

  // Read FSM
  rd_state_e      r_rd_state, w_rd_state_d;
  logic [RpW-1:0] r_rcnt, w_rcnt_d;
  logic [7:0]     r_d_out, w_d_out_d;
  logic           r_d_oe, w_d_oe_d;
  logic           r_rxf, w_rxf_d;

  // Write FSM
  wr_state_e      r_wr_state, w_wr_state_d;
  logic [WpW-1:0] r_wcnt, w_wcnt_d;
  logic           r_txe, w_txe_d;

  logic r_host_tx_ready, r_host_rx_valid;
  logic r_err_rd, r_err_wr, r_err_bus;

  assign w_rd_fall = r_rd_q & ~rx_245;
  assign w_rd_rise = ~r_rd_q & rx_245;
  assign w_wr_fall = r_wr_q & ~wr_245;
  assign w_wr_rise = ~r_wr_q & wr_245;

  assign w_rx_push = host_tx_valid & r_host_tx_ready;
  assign w_tx_pop  = r_host_rx_valid & host_rx_ready;

  always_comb begin
    w_rx_count_d = r_rx_count;
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_count_d = r_rx_count + RxCw'(1);
      2'b01:   w_rx_count_d = r_rx_count - RxCw'(1);
      default: w_rx_count_d = r_rx_count;
    endcase
  end

  always_comb begin
    w_tx_count_d = r_tx_count;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_count_d = r_tx_count + TxCw'(1);
      2'b01:   w_tx_count_d = r_tx_count - TxCw'(1);
      default: w_tx_count_d = r_tx_count;
    endcase
  end

  // Read FSM next state and outputs
  always_comb begin
    w_rd_state_d = r_rd_state;
    w_rcnt_d     = r_rcnt;
    w_d_out_d    = r_d_out;
    w_d_oe_d     = r_d_oe;
    w_rx_pop     = 1'b0;
    case (r_rd_state)
      RIdle: begin
        w_d_oe_d = 1'b0;
        if (w_rd_fall && !r_rxf) begin
          w_rx_pop     = 1'b1;
          w_d_out_d    = r_rx_mem[r_rx_rd_ptr];
          w_d_oe_d     = 1'b1;
          w_rd_state_d = RActive;
        end
      end
      RActive: begin
        if (w_rd_rise) begin
          w_d_oe_d     = 1'b0;
          w_rcnt_d     = RpW'(RXF_PRECHARGE);
          w_rd_state_d = RPrecharge;
        end
      end
      RPrecharge: begin
        w_rcnt_d = r_rcnt - RpW'(1);
        if (w_rcnt_d == '0) w_rd_state_d = RIdle;
      end
      default: begin
        w_d_oe_d     = 1'b0;
        w_rd_state_d = RIdle;
      end
    endcase
    // RXF# tracks the post-update level only once the FSM is back in idle.
    w_rxf_d = (w_rd_state_d == RIdle) ? (w_rx_count_d == '0) : 1'b1;
  end

  // Write FSM next state and outputs
  always_comb begin
    w_wr_state_d = r_wr_state;
    w_wcnt_d     = r_wcnt;
    w_tx_push    = 1'b0;
    case (r_wr_state)
      WIdle: begin
        if (w_wr_fall && !r_txe) begin
          w_tx_push    = 1'b1;
          w_wr_state_d = WActive;
        end
      end
      WActive: begin
        if (w_wr_rise) begin
          w_wcnt_d     = WpW'(TXE_PRECHARGE);
          w_wr_state_d = WPrecharge;
        end
      end
      WPrecharge: begin
        w_wcnt_d = r_wcnt - WpW'(1);
        if (w_wcnt_d == '0) w_wr_state_d = WIdle;
      end
      default: w_wr_state_d = WIdle;
    endcase
    w_txe_d = (w_wr_state_d == WIdle) ? (w_tx_count_d == TxFull) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_q          <= 1'b1;
      r_wr_q          <= 1'b1;
      r_rx_wr_ptr     <= '0;
      r_rx_rd_ptr     <= '0;
      r_rx_count      <= '0;
      r_tx_wr_ptr     <= '0;
      r_tx_rd_ptr     <= '0;
      r_tx_count      <= '0;
      r_rd_state      <= RIdle;
      r_rcnt          <= '0;
      r_d_out         <= 8'h00;
      r_d_oe          <= 1'b0;
      r_rxf           <= 1'b1;
      r_wr_state      <= WIdle;
      r_wcnt          <= '0;
      r_txe           <= 1'b1;
      r_host_tx_ready <= 1'b0;
      r_host_rx_valid <= 1'b0;
      r_err_rd        <= 1'b0;
      r_err_wr        <= 1'b0;
      r_err_bus       <= 1'b0;
    end else begin
      r_rd_q          <= rx_245;
      r_wr_q          <= wr_245;
      r_rx_count      <= w_rx_count_d;
      r_tx_count      <= w_tx_count_d;
      if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + RxAw'(1);
      if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + RxAw'(1);
      if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + TxAw'(1);
      if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + TxAw'(1);
      r_rd_state      <= w_rd_state_d;
      r_rcnt          <= w_rcnt_d;
      r_d_out         <= w_d_out_d;
      r_d_oe          <= w_d_oe_d;
      r_rxf           <= w_rxf_d;
      r_wr_state      <= w_wr_state_d;
      r_wcnt          <= w_wcnt_d;
      r_txe           <= w_txe_d;
      r_host_tx_ready <= (w_rx_count_d != RxFull);
      r_host_rx_valid <= (w_tx_count_d != '0);
      r_err_rd        <= r_err_rd | (w_rd_fall & r_rxf);
      r_err_wr        <= r_err_wr | (w_wr_fall & r_txe);
      r_err_bus       <= r_err_bus | (r_d_oe & ~wr_245);
    end
  end

  // Storage needs no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= host_tx_data;
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= d_in;
  end

  assign d_out         = r_d_out;
  assign d_oe          = r_d_oe;
  assign rxf_245       = r_rxf;
  assign txe_245       = r_txe;
  assign host_tx_ready = r_host_tx_ready;
  assign host_rx_valid = r_host_rx_valid;
  assign host_rx_data  = r_tx_mem[r_tx_rd_ptr];
  assign err_rd        = r_err_rd;
  assign err_wr        = r_err_wr;
  assign err_bus       = r_err_bus;

endmodule

// File: tb/tb_ft245_device_emulator.sv
// Scoreboard bench for ft245_device_emulator: host bytes are queued on push and compared when
// read over RD#; FPGA bytes are queued on WR# and compared when the host drains them.
module tb_ft245_device_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       d_oe, rxf_245, txe_245;
  logic       rx_245 = 1'b1;
  logic       wr_245 = 1'b1;
  logic [7:0] host_tx_data = 8'h00;
  logic       host_tx_valid = 1'b0;
  logic       host_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready = 1'b0;
  logic       err_rd, err_wr, err_bus;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  ft245_device_emulator #(
    .RX_DEPTH(16), .TX_DEPTH(16), .RXF_PRECHARGE(2), .TXE_PRECHARGE(2)
  ) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
    .rxf_245(rxf_245), .rx_245(rx_245), .txe_245(txe_245), .wr_245(wr_245),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready), .host_rx_data(host_rx_data),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .err_rd(err_rd), .err_wr(err_wr), .err_bus(err_bus)
  );

  // Stimulus drivers: everything is applied and sampled on the falling edge.
  task automatic host_push(input logic [7:0] b, output bit to);
    int n = 0;
    @(negedge clk);
    while (host_tx_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    to = (host_tx_ready !== 1'b1);
    if (!to) begin
      host_tx_data = b; host_tx_valid = 1'b1;
      @(negedge clk);
      host_tx_valid = 1'b0;
    end
  endtask

  task automatic host_pop(output logic [7:0] b, output bit to);
    int n = 0;
    @(negedge clk);
    while (host_rx_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    to = (host_rx_valid !== 1'b1);
    b = host_rx_data;
    if (!to) begin
      host_rx_ready = 1'b1;
      @(negedge clk);
      host_rx_ready = 1'b0;
    end
  endtask

  // Three-cycle RD# pulse; reports data seen, whether d_oe/d_out behaved, and RXF# precharge.
  task automatic fpga_read(output logic [7:0] b, output bit oe_ok, output bit pre_ok,
                           output bit to);
    int n = 0;
    oe_ok = 1'b1; pre_ok = 1'b1; b = 8'hxx;
    @(negedge clk);
    while (rxf_245 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    to = (rxf_245 !== 1'b0);
    if (!to) begin
      rx_245 = 1'b0;
      @(negedge clk);
      b = d_out;
      if (d_oe !== 1'b1) oe_ok = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (d_oe !== 1'b1 || d_out !== b) oe_ok = 1'b0;
      end
      rx_245 = 1'b1;
      @(negedge clk);
      if (d_oe !== 1'b0) oe_ok = 1'b0;
      if (rxf_245 !== 1'b1) pre_ok = 1'b0;
      @(negedge clk);
      if (rxf_245 !== 1'b1) pre_ok = 1'b0;
    end
  endtask

  task automatic fpga_write(input logic [7:0] b, input bit wait_txe, output bit to);
    int n = 0;
    @(negedge clk);
    while (wait_txe && txe_245 !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    to = wait_txe && (txe_245 !== 1'b0);
    if (!to) begin
      d_in = b; wr_245 = 1'b0;
      repeat (2) @(negedge clk);
      wr_245 = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rxf_245 !== 1'b1) begin errors++; $display("FAIL reset_rxf got %b want 1", rxf_245); end
    checks++; if (txe_245 !== 1'b1) begin errors++; $display("FAIL reset_txe got %b want 1", txe_245); end
    checks++; if (d_oe !== 1'b0 || d_out !== 8'h00) begin
      errors++; $display("FAIL reset_bus got oe=%b d=%h want oe=0 d=00", d_oe, d_out); end
    checks++; if (host_tx_ready !== 1'b0 || host_rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_host got rdy=%b vld=%b want 0 0", host_tx_ready, host_rx_valid); end
    checks++; if ({err_rd, err_wr, err_bus} !== 3'b000) begin
      errors++; $display("FAIL reset_err got %b want 000", {err_rd, err_wr, err_bus}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", host_tx_ready); end
    checks++; if (rxf_245 !== 1'b1 || txe_245 !== 1'b0) begin
      errors++; $display("FAIL release_flags got rxf=%b txe=%b want 1 0", rxf_245, txe_245); end
  endtask

  task automatic test_read_basic();
    logic [7:0] b, exp; bit oe_ok, pre_ok, to;
    host_push(8'hA5, to); if (!to) rx_q.push_back(8'hA5);
    host_push(8'h3C, to); if (!to) rx_q.push_back(8'h3C);
    for (int i = 0; i < 2; i++) begin
      fpga_read(b, oe_ok, pre_ok, to);
      exp = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
      checks++; if (to || b !== exp) begin
        errors++; $display("FAIL read_data[%0d] got %h (timeout=%0d) want %h", i, b, to, exp); end
      checks++; if (!oe_ok) begin errors++; $display("FAIL read_oe[%0d] got bad d_oe window want high only while RD# low", i); end
      checks++; if (!pre_ok) begin errors++; $display("FAIL read_precharge[%0d] got rxf low too early want >=2 high cycles", i); end
    end
    @(negedge clk);
    checks++; if (rxf_245 !== 1'b1) begin errors++; $display("FAIL read_empty_rxf got %b want 1", rxf_245); end
    checks++; if (err_rd !== 1'b0) begin errors++; $display("FAIL read_no_err got %b want 0", err_rd); end
  endtask

  task automatic test_tx_fill();
    logic [7:0] b, exp; bit to;
    for (int i = 0; i < 16; i++) begin
      fpga_write(8'(i), 1'b1, to);
      if (to) begin errors++; checks++; $display("FAIL fill_wait[%0d] got txe=%b want 0", i, txe_245); end
      else tx_q.push_back(8'(i));
    end
    checks++; if (txe_245 !== 1'b1) begin errors++; $display("FAIL full_txe got %b want 1", txe_245); end
    checks++; if (err_wr !== 1'b0) begin errors++; $display("FAIL fill_no_err got %b want 0", err_wr); end
    fpga_write(8'hFF, 1'b0, to);
    checks++; if (err_wr !== 1'b1) begin errors++; $display("FAIL overflow_err got %b want 1", err_wr); end
    for (int i = 0; i < 16; i++) begin
      host_pop(b, to);
      exp = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
      checks++; if (to || b !== exp) begin
        errors++; $display("FAIL drain[%0d] got %h (timeout=%0d) want %h", i, b, to, exp); end
    end
    checks++; if (host_rx_valid !== 1'b0 || txe_245 !== 1'b0) begin
      errors++; $display("FAIL drained got vld=%b txe=%b want 0 0", host_rx_valid, txe_245); end
  endtask

  task automatic test_rd_empty();
    bit oe_seen = 1'b0;
    checks++; if (err_rd !== 1'b0) begin errors++; $display("FAIL rd_empty_pre got %b want 0", err_rd); end
    @(negedge clk);
    rx_245 = 1'b0;
    repeat (3) begin @(negedge clk); if (d_oe !== 1'b0) oe_seen = 1'b1; end
    rx_245 = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (oe_seen) begin errors++; $display("FAIL rd_empty_oe got d_oe=1 want 0"); end
    checks++; if (err_rd !== 1'b1) begin errors++; $display("FAIL rd_empty_err got %b want 1", err_rd); end
    checks++; if (rxf_245 !== 1'b1) begin errors++; $display("FAIL rd_empty_rxf got %b want 1", rxf_245); end
  endtask

  task automatic test_simul_and_bus();
    logic [7:0] b, exp; bit to;
    host_push(8'h11, to); if (!to) rx_q.push_back(8'h11);
    @(negedge clk);
    // Host push lands in the same cycle the read FSM pops the lone byte.
    rx_245 = 1'b0; host_tx_data = 8'h22; host_tx_valid = 1'b1;
    rx_q.push_back(8'h22);
    @(negedge clk);
    host_tx_valid = 1'b0;
    exp = rx_q.pop_front();
    checks++; if (d_oe !== 1'b1 || d_out !== exp) begin
      errors++; $display("FAIL simul_data got oe=%b d=%h want 1 %h", d_oe, d_out, exp); end
    repeat (2) @(negedge clk);
    rx_245 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rxf_245 !== 1'b0) begin errors++; $display("FAIL simul_rxf got %b want 0", rxf_245); end
    checks++; if (err_bus !== 1'b0 || txe_245 !== 1'b0) begin
      errors++; $display("FAIL bus_pre got err_bus=%b txe=%b want 0 0", err_bus, txe_245); end
    rx_245 = 1'b0;
    @(negedge clk);
    exp = rx_q.pop_front();
    checks++; if (d_oe !== 1'b1 || d_out !== exp) begin
      errors++; $display("FAIL second_data got oe=%b d=%h want 1 %h", d_oe, d_out, exp); end
    wr_245 = 1'b0; d_in = 8'h77; tx_q.push_back(8'h77);
    @(negedge clk);
    wr_245 = 1'b1;
    @(negedge clk);
    rx_245 = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (err_bus !== 1'b1) begin errors++; $display("FAIL bus_err got %b want 1", err_bus); end
    checks++; if (rxf_245 !== 1'b1) begin errors++; $display("FAIL second_rxf got %b want 1", rxf_245); end
    host_pop(b, to);
    exp = tx_q.pop_front();
    checks++; if (to || b !== exp) begin
      errors++; $display("FAIL bus_write got %h (timeout=%0d) want %h", b, to, exp); end
    checks++; if (err_wr !== 1'b1 || err_rd !== 1'b1) begin
      errors++; $display("FAIL sticky got wr=%b rd=%b want 1 1", err_wr, err_rd); end
  endtask

  task automatic test_reset_mid_read();
    bit to;
    for (int i = 0; i < 4; i++) begin
      host_push(8'hC0 + 8'(i), to); if (!to) rx_q.push_back(8'hC0 + 8'(i));
    end
    @(negedge clk);
    rx_245 = 1'b0;
    @(negedge clk);
    checks++; if (d_oe !== 1'b1) begin errors++; $display("FAIL mid_active got d_oe=%b want 1", d_oe); end
    rst = 1'b0;
    @(negedge clk);
    rx_245 = 1'b1;
    rx_q.delete();
    checks++; if (d_oe !== 1'b0 || rxf_245 !== 1'b1) begin
      errors++; $display("FAIL mid_reset got oe=%b rxf=%b want 0 1", d_oe, rxf_245); end
    checks++; if ({err_rd, err_wr, err_bus} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_err got %b want 000", {err_rd, err_wr, err_bus}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (host_tx_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", host_tx_ready); end
    repeat (3) @(negedge clk);
    checks++; if (rxf_245 !== 1'b1) begin errors++; $display("FAIL mid_release_rxf got %b want 1", rxf_245); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_tx_fill();
    test_rd_empty();
    test_simul_and_bus();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ft245_device_emulator.md
Name: ft245_device_emulator

Overview:
- Synthesizable model of the FTDI side of the FT245 asynchronous FIFO interface: drives RXF#/TXE#, responds to RD#/WR#, and sources/sinks the shared data bus.
- Used in loopback benches and on-board self-test opposite the FPGA-side FT245 FIFO interface.
- A host-side simple interface feeds bytes toward the FPGA (RX FIFO) and drains bytes written by the FPGA (TX FIFO).
- All FT245 strobes are synchronous to clk; no synchronizers.

Parameters:
RX_DEPTH, 16, RX FIFO depth in bytes (power of 2, >=2)
TX_DEPTH, 16, TX FIFO depth in bytes (power of 2, >=2)
RXF_PRECHARGE, 2, cycles RXF# held high after RD# rises (>=1)
TXE_PRECHARGE, 2, cycles TXE# held high after WR# rises (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
d_in  in  8  data bus as seen from the pins (FPGA-driven during writes)
d_out  out  8  data driven onto bus during reads
d_oe  out  1  bus output enable for d_out
rxf_245  out  1  RXF#, low = byte available to read
rx_245  in  1  RD# from FPGA, active-low
txe_245  out  1  TXE#, low = space available to write
wr_245  in  1  WR# from FPGA, active-low
host_tx_data  in  8  byte to queue toward FPGA
host_tx_valid  in  1  host_tx_data valid
host_tx_ready  out  1  RX FIFO not full
host_rx_data  out  8  byte written by FPGA (TX FIFO head)
host_rx_valid  out  1  TX FIFO not empty
host_rx_ready  in  1  host consumes host_rx_data
err_rd  out  1  sticky: RD# fell while RXF# high
err_wr  out  1  sticky: WR# fell while TXE# high
err_bus  out  1  sticky: d_oe high while WR# low

Behaviour:
- Reset (rst==0 at posedge): both FIFOs emptied; rxf_245=1, txe_245=1, d_oe=0, d_out=8'h00, host_tx_ready=0, host_rx_valid=0, all err_* cleared; both FSMs enter IDLE. Reset mid-transfer aborts it; the byte in flight is discarded. First cycle after reset release: host_tx_ready=1.
- Edge detection: registered copies rd_q/wr_q; fall = prev 1 & now 0; rise = prev 0 & now 1. Both registers reset to 1.
- RX FIFO: pushed by the host on host_tx_valid & host_tx_ready. Popped only by the read FSM. Simultaneous push and pop in one cycle: count unchanged. Push when full: impossible, because host_tx_ready=0.
- Read FSM:
  - R_IDLE: rxf_245 = (rx_count==0), registered.
  - RD# fall with rxf_245==0: pop the head into d_out, d_oe=1 on the next cycle, go to R_ACTIVE.
  - RD# fall with rxf_245==1: set err_rd, d_oe stays 0, no pop, stay in R_IDLE.
  - R_ACTIVE: rxf_245=1, d_out held stable, d_oe=1. On RD# rise: d_oe=0 next cycle, load counter=RXF_PRECHARGE, go to R_PRECHARGE.
  - R_PRECHARGE: rxf_245=1; counter decrements each cycle; at 0 go to R_IDLE.
  - Minimum byte-to-byte read period = 1 (fall) + active + RXF_PRECHARGE + 1 cycles.
- TX FIFO: pushed only by the write FSM. Popped by the host on host_rx_valid & host_rx_ready. host_rx_data = head, combinational from FIFO storage. Simultaneous push and pop: count unchanged.
- Write FSM:
  - W_IDLE: txe_245 = (tx_count==TX_DEPTH), registered.
  - WR# fall with txe_245==0: push d_in, sampled in the same cycle WR# is first seen low; go to W_ACTIVE.
  - WR# fall with txe_245==1: set err_wr, byte dropped, stay in W_IDLE.
  - W_ACTIVE: txe_245=1. On WR# rise: counter=TXE_PRECHARGE, go to W_PRECHARGE.
  - W_PRECHARGE: txe_245=1 until the counter reaches 0, then go to W_IDLE.
- RXF#/TXE# reflect the FIFO level after the current cycle's host push/pop, one cycle late (registered). The write FSM samples the registered txe_245, so the one-cycle lag cannot overflow the FIFO.
- RD# and WR# both falling in the same cycle: both FSMs act independently. err_bus sets in any cycle where d_oe==1 and wr_245==0.
- FIFO pointers wrap modulo depth. Count is held in log2(DEPTH)+1 bits to distinguish full from empty.
- err_* are set-only until reset.

Test Plan:
- Reset with rst=0 for 3 cycles, then release -> rxf_245=1, txe_245=1, d_oe=0, err_*=0; host_tx_ready=1 the following cycle.
- Host pushes 0xA5,0x3C; FPGA pulses RD# low for 3 cycles twice, RXF_PRECHARGE=2 -> d_out=0xA5 then 0x3C with d_oe high only while RD# low; rxf_245 high for >=2 cycles after each RD# rise; rxf_245=1 after the second byte.
- FPGA writes 16 bytes 0x00..0x0F with TX_DEPTH=16 and no host pops -> txe_245 stays 1 after the 16th; a 17th WR# pulse with 0xFF sets err_wr; host then pops 0x00..0x0F in order and txe_245 returns to 0.
- RD# pulse with the RX FIFO empty -> err_rd=1, d_oe stays 0, rx_count unchanged.
- Host pushes and the read FSM pops in the same cycle at rx_count=1 -> count stays 1, rxf_245 low again after precharge. Drive WR# low while d_oe=1 -> err_bus=1.
- Assert rst=0 mid-read (R_ACTIVE) with 4 bytes queued -> next cycle d_oe=0, rxf_245=1; after release host_tx_ready=1, rxf_245 stays 1 (FIFO empty).
